jtkicker_gfx_arb: RTL

// Shares one SDRAM graphics read slot between the scroll tile fetcher and the object fetcher.

---
 rtl/jtkicker_gfx_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/jtkicker_gfx_arb.sv
// Arbitrates one SDRAM graphics read slot between the scroll and object fetchers, each with a
// one-entry address/data buffer. Optional statistics ports: define JTKICKER_ARB_STATS_EN.
module jtkicker_gfx_arb #(
  parameter int unsigned AW         = 16,
  parameter int unsigned SAW        = 13,
  parameter int unsigned OAW        = 14,
  parameter int unsigned SCR_OFFSET = 'h0,
  parameter int unsigned OBJ_OFFSET = 'h2000,
  parameter int unsigned MAXWAIT    = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           LHBL,
  input  logic           scr_cs,
  input  logic [SAW-1:0] scr_addr,
  output logic           scr_ok,
  output logic [31:0]    scr_data,
  input  logic           obj_cs,
  input  logic [OAW-1:0] obj_addr,
  output logic           obj_ok,
  output logic [31:0]    obj_data,
  output logic           rom_cs,
  output logic [AW-1:0]  rom_addr,
  input  logic [31:0]    rom_data,
  input  logic           rom_ok
`ifdef JTKICKER_ARB_STATS_EN
  ,
  output logic [15:0]    st_conflict,
  output logic [3:0]     st_maxwait
`endif
);

  localparam int unsigned GAW = (SAW > OAW) ? SAW : OAW;
  localparam int unsigned WW  = $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e         state_q, state_d;
  logic           rom_cs_q, rom_cs_d;
  logic [AW-1:0]  rom_addr_q, rom_addr_d;
  logic [GAW-1:0] g_addr_q, g_addr_d;
  logic           g_obj_q, g_obj_d;
  logic [SAW-1:0] scr_last_q, scr_last_d;
  logic [OAW-1:0] obj_last_q, obj_last_d;
  logic           scr_valid_q, scr_valid_d;
  logic           obj_valid_q, obj_valid_d;
  logic [31:0]    scr_data_q, scr_data_d;
  logic [31:0]    obj_data_q, obj_data_d;
  logic [WW-1:0]  scr_wait_q, scr_wait_d;
  logic [WW-1:0]  obj_wait_q, obj_wait_d;

  logic scr_hit, obj_hit, scr_pend, obj_pend, both_pend;
  logic grant, gnt_obj, win_obj;

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v == WMAX) ? v : v + WW'(1);
  endfunction

  assign scr_hit   = scr_cs & scr_valid_q & (scr_addr == scr_last_q);
  assign obj_hit   = obj_cs & obj_valid_q & (obj_addr == obj_last_q);
  assign scr_pend  = scr_cs & ~scr_hit;
  assign obj_pend  = obj_cs & ~obj_hit;
  assign both_pend = scr_pend & obj_pend;

  assign scr_ok   = scr_hit;
  assign obj_ok   = obj_hit;
  assign scr_data = scr_data_q;
  assign obj_data = obj_data_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

  // Starved loser overrides LHBL priority; scroll breaks a tie of two starved requesters.
  always_comb begin
    if (LHBL) win_obj = (obj_wait_q == WMAX) & (scr_wait_q != WMAX);
    else      win_obj = (scr_wait_q != WMAX);
  end

  always_comb begin
    state_d     = state_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    g_addr_d    = g_addr_q;
    g_obj_d     = g_obj_q;
    scr_last_d  = scr_last_q;
    obj_last_d  = obj_last_q;
    scr_valid_d = scr_valid_q;
    obj_valid_d = obj_valid_q;
    scr_data_d  = scr_data_q;
    obj_data_d  = obj_data_q;
    scr_wait_d  = scr_wait_q;
    obj_wait_d  = obj_wait_q;
    grant       = 1'b0;
    gnt_obj     = 1'b0;
    case (state_q)
      StIdle: begin
        if (scr_pend | obj_pend) begin
          grant    = 1'b1;
          gnt_obj  = both_pend ? win_obj : obj_pend;
          g_obj_d  = gnt_obj;
          rom_cs_d = 1'b1;
          state_d  = StIssue;
          if (gnt_obj) begin
            g_addr_d   = GAW'(obj_addr);
            rom_addr_d = AW'(obj_addr) + AW'(OBJ_OFFSET);
            obj_wait_d = '0;
            if (scr_pend) scr_wait_d = sat_inc(scr_wait_q);
          end else begin
            g_addr_d   = GAW'(scr_addr);
            rom_addr_d = AW'(scr_addr) + AW'(SCR_OFFSET);
            scr_wait_d = '0;
            if (obj_pend) obj_wait_d = sat_inc(obj_wait_q);
          end
        end
      end
      // rom_ok here may still belong to the previous address
      StIssue: state_d = StWait;
      StWait: begin
        if (rom_ok) begin
          rom_cs_d = 1'b0;
          state_d  = StIdle;
          if (g_obj_q) begin
            obj_data_d  = rom_data;
            obj_last_d  = g_addr_q[OAW-1:0];
            obj_valid_d = 1'b1;
          end else begin
            scr_data_d  = rom_data;
            scr_last_d  = g_addr_q[SAW-1:0];
            scr_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      g_addr_q    <= '0;
      g_obj_q     <= 1'b0;
      scr_last_q  <= '0;
      obj_last_q  <= '0;
      scr_valid_q <= 1'b0;
      obj_valid_q <= 1'b0;
      scr_data_q  <= '0;
      obj_data_q  <= '0;
      scr_wait_q  <= '0;
      obj_wait_q  <= '0;
    end else begin
      state_q     <= state_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      g_addr_q    <= g_addr_d;
      g_obj_q     <= g_obj_d;
      scr_last_q  <= scr_last_d;
      obj_last_q  <= obj_last_d;
      scr_valid_q <= scr_valid_d;
      obj_valid_q <= obj_valid_d;
      scr_data_q  <= scr_data_d;
      obj_data_q  <= obj_data_d;
      scr_wait_q  <= scr_wait_d;
      obj_wait_q  <= obj_wait_d;
    end
  end

`ifdef JTKICKER_ARB_STATS_EN
  logic [15:0]   st_conflict_q, st_conflict_d;
  logic [3:0]    st_maxwait_q, st_maxwait_d;
  logic [WW-1:0] wait_hi;

  always_comb begin
    st_conflict_d = st_conflict_q;
    st_maxwait_d  = st_maxwait_q;
    wait_hi       = (scr_wait_d > obj_wait_d) ? scr_wait_d : obj_wait_d;
    if (grant && both_pend && st_conflict_q != 16'hFFFF) st_conflict_d = st_conflict_q + 16'd1;
    if (4'(wait_hi) > st_maxwait_q) st_maxwait_d = 4'(wait_hi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_conflict_q <= '0;
      st_maxwait_q  <= '0;
    end else begin
      st_conflict_q <= st_conflict_d;
      st_maxwait_q  <= st_maxwait_d;
    end
  end

  assign st_conflict = st_conflict_q;
  assign st_maxwait  = st_maxwait_q;
`endif

endmodule
